// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Frame length depends on the PISO_PARITY_EN build macro.
package piso_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } state_t;

   // Bits per frame: data bits, plus one trailing even-parity bit when enabled.
   function automatic int FRAME_LEN(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   // Bit counter width; sized so that WIDTH+1 always fits.
   function automatic int CNT_W(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word in, MSB-first bit stream out.
// Build macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pin_valid,
   input  logic [WIDTH-1:0] pin,
   output logic             pin_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int             CW       = CNT_W(WIDTH);
   localparam int             FRAME    = FRAME_LEN(WIDTH);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(FRAME - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [CW-1:0]    r_cnt,   w_cnt_nxt;
   logic             r_sout,  w_sout_nxt;
   logic             r_sout_valid, w_sout_valid_nxt;
   logic             w_ready;
   logic             w_accept;
   logic             w_cnt_zero;
`ifdef PISO_PARITY_EN
   logic             r_parity, w_parity_nxt;
`endif

   assign w_cnt_zero = (r_cnt == '0);
   // Ready comes from registered state only, so it never loops back through pin_valid.
   assign w_ready    = (r_state == S_IDLE) || w_cnt_zero;
   assign w_accept   = pin_valid && w_ready;

   // NOTE: every next-state signal gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_shreg_nxt      = r_shreg;
      w_cnt_nxt        = r_cnt;
      w_sout_nxt       = r_sout;
      w_sout_valid_nxt = r_sout_valid;
`ifdef PISO_PARITY_EN
      w_parity_nxt     = r_parity;
`endif

      if (r_state == S_SHIFT && !w_cnt_zero) begin
         w_shreg_nxt      = r_shreg << 1;
         w_cnt_nxt        = r_cnt - CNT_ONE;
         w_sout_nxt       = r_shreg[WIDTH-2];
`ifdef PISO_PARITY_EN
         // Counter reaching zero next cycle marks the parity slot.
         if (r_cnt == CNT_ONE) begin
            w_sout_nxt = r_parity;
         end
`endif
      end else if (w_accept) begin
         // Covers both the idle load and the zero-gap back-to-back reload.
         w_state_nxt      = S_SHIFT;
         w_shreg_nxt      = pin;
         w_cnt_nxt        = CNT_LOAD;
         w_sout_nxt       = pin[WIDTH-1];
         w_sout_valid_nxt = 1'b1;
`ifdef PISO_PARITY_EN
         w_parity_nxt     = ^pin;
`endif
      end else if (r_state == S_SHIFT) begin
         // Frame done with nothing queued; sout keeps its last bit.
         w_state_nxt      = S_IDLE;
         w_sout_valid_nxt = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_cnt        <= '0;
         r_sout       <= 1'b0;
         r_sout_valid <= 1'b0;
`ifdef PISO_PARITY_EN
         r_parity     <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_shreg      <= w_shreg_nxt;
         r_cnt        <= w_cnt_nxt;
         r_sout       <= w_sout_nxt;
         r_sout_valid <= w_sout_valid_nxt;
`ifdef PISO_PARITY_EN
         r_parity     <= w_parity_nxt;
`endif
      end
   end

   assign pin_ready  = w_ready;
   assign sout       = r_sout;
   assign sout_valid = r_sout_valid;
   assign sout_last  = r_sout_valid && w_cnt_zero;
   assign busy       = (r_state == S_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: scoreboard of expected serial bits plus per-scenario checks.
// Define PISO_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_piso_serializer;

   localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             pin_valid;
   logic [WIDTH-1:0] pin;
   logic             pin_ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_last;
   logic             busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [3:0] rx;

   piso_serializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pin_valid  (pin_valid),
      .pin        (pin),
      .pin_ready  (pin_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Loopback receiver: 4-bit shift-left register that shifts only on valid bits.
   always @(posedge clk) begin
      if (rst) rx <= '0;
      else if (sout_valid) rx <= {rx[2:0], sout};
   end

   // Scoreboard: pop the bit on screen, then push a frame for any handshake about to happen.
   always @(negedge clk) begin
      if (!rst) begin
         if (sout_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_bit: got sout=%b sout_last=%b, expected no frame bit", sout, sout_last);
            end else begin
               e = sb.pop_front();
               if (sout !== e.b || sout_last !== e.last) begin
                  errors++;
                  $display("FAIL sb_bit: got sout=%b sout_last=%b, expected sout=%b sout_last=%b",
                           sout, sout_last, e.b, e.last);
               end
            end
         end
         if (pin_valid && pin_ready) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
               sb.push_back('{b: pin[i], last: 1'b0});
`else
               sb.push_back('{b: pin[i], last: (i == 0)});
`endif
            end
`ifdef PISO_PARITY_EN
            sb.push_back('{b: ^pin, last: 1'b1});
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers w until accepted; returns in cycle 1 after the accept edge.
   task automatic send_word(input logic [WIDTH-1:0] w);
      int n = 0;
      pin_valid = 1'b1;
      pin       = w;
      while (!pin_ready && n < 50) begin
         tick();
         n++;
      end
      if (!pin_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got pin_ready=%b, expected 1 within 50 cycles", pin_ready);
      end
      tick();
      pin_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || pin_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_state: got busy=%b sout_valid=%b sout_last=%b pin_ready=%b, expected 0 0 0 1",
                  busy, sout_valid, sout_last, pin_ready);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending bits, expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pin_valid = 1'b0;
      pin       = '0;
      tick();
      tick();
      checks++;
      if (sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || busy !== 1'b0 || pin_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: got sout=%b sout_valid=%b sout_last=%b busy=%b pin_ready=%b, expected 0 0 0 0 1",
                  sout, sout_valid, sout_last, busy, pin_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [WIDTH-1:0] w = 4'b1011;
      send_word(w);
      for (int k = 1; k <= WIDTH; k++) begin
         checks++;
         if (sout_valid !== 1'b1 || busy !== 1'b1 || sout !== w[WIDTH-k] ||
             sout_last !== (k == FRAME) || pin_ready !== (k == FRAME)) begin
            errors++;
            $display("FAIL single_cycle%0d: got sout=%b valid=%b last=%b ready=%b busy=%b, expected %b 1 %b %b 1",
                     k, sout, sout_valid, sout_last, pin_ready, busy, w[WIDTH-k], (k == FRAME), (k == FRAME));
         end
         tick();
      end
      wait_idle();
   endtask

   task automatic test_loopback();
      send_word(4'b1101);
      for (int k = 1; k < WIDTH; k++) tick();
      tick();
      checks++;
      if (rx !== 4'b1101) begin
         errors++;
         $display("FAIL loopback_rx: got %b, expected 1101", rx);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int acc = -1;
      send_word(4'b1011);
      pin_valid = 1'b1;
      pin       = 4'b0110;
      for (int c = 1; c <= 2 * FRAME; c++) begin
         checks++;
         if (sout_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got sout_valid=%b busy=%b, expected 1 1", c, sout_valid, busy);
         end
         if (pin_valid && pin_ready) acc = c;
         tick();
         if (acc == c) pin_valid = 1'b0;
      end
      checks++;
      if (acc != FRAME) begin
         errors++;
         $display("FAIL b2b_accept_cycle: got %0d, expected %0d", acc, FRAME);
      end
      wait_idle();
   endtask

   task automatic test_busy_offer();
      int acc = -1;
      send_word(4'b1010);
      for (int k = 1; k < FRAME - 2; k++) tick();
      pin_valid = 1'b1;
      pin       = 4'b0001;
      for (int c = FRAME - 2; c <= FRAME + 2; c++) begin
         checks++;
         if (pin_ready !== (c == FRAME)) begin
            errors++;
            $display("FAIL busy_ready_cycle%0d: got pin_ready=%b, expected %b", c, pin_ready, (c == FRAME));
         end
         if (pin_ready) begin
            acc = c;
            tick();
            pin_valid = 1'b0;
            break;
         end
         tick();
      end
      pin_valid = 1'b0;
      checks++;
      if (acc != FRAME) begin
         errors++;
         $display("FAIL busy_accept_cycle: got %0d, expected %0d", acc, FRAME);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      send_word(4'b1110);
      tick();
      rst       = 1'b1;
      pin_valid = 1'b1;
      pin       = 4'b0101;
      tick();
      checks++;
      if (sout_valid !== 1'b0 || busy !== 1'b0 || pin_ready !== 1'b1 || sout_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got sout_valid=%b busy=%b pin_ready=%b sout_last=%b, expected 0 0 1 0",
                  sout_valid, busy, pin_ready, sout_last);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || sout_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept: got busy=%b sout_valid=%b, expected 0 0", busy, sout_valid);
      end
      rst       = 1'b0;
      pin_valid = 1'b0;
      sb.delete();
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (sout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet_cycle%0d: got sout_valid=%b busy=%b, expected 0 0", c, sout_valid, busy);
         end
         tick();
      end
      wait_idle();
   endtask

`ifdef PISO_PARITY_EN
   task automatic test_parity();
      logic [WIDTH-1:0] words [2];
      logic             par   [2];
      words[0] = 4'b1011;
      par[0]   = 1'b1;
      words[1] = 4'b1001;
      par[1]   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         send_word(words[i]);
         for (int k = 1; k < FRAME; k++) tick();
         checks++;
         if (sout_valid !== 1'b1 || sout !== par[i] || sout_last !== 1'b1) begin
            errors++;
            $display("FAIL parity_bit%0d: got sout=%b valid=%b last=%b, expected %b 1 1",
                     i, sout, sout_valid, sout_last, par[i]);
         end
         wait_idle();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_loopback();
      test_back_to_back();
      test_busy_offer();
      test_reset_mid();
`ifdef PISO_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
